// File: rtl/router_ctrl.sv
// Router packet-steering controller: FSM that sequences header/payload/parity writes into three FIFOs.
// Define ROUTER_CTRL_TIMEOUT_EN to add per-FIFO idle-read timeout flushes on soft_reset.

`ifdef ROUTER_CTRL_TIMEOUT_EN
module router_timeout (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    logic [4:0] cnt;

    // Flush fires on the 30th consecutive cycle of data sitting unread
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (vld && !rd) begin
                if (cnt == 5'd29) begin
                    cnt        <= '0;
                    soft_reset <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule
`endif

module router_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] empty,
    input  logic [2:0] full,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic [2:0] soft_reset,
    output logic [2:0] vld_out,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       fifo_full
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state, next_state;
    logic [1:0] addr_reg;
    logic [1:0] hdr_addr;
    logic       hdr_empty;
    logic       reg_empty;
    logic       sel_soft_reset;
    logic [2:0] addr_onehot;
    logic       unused_data;

    assign hdr_addr    = data_in[1:0];
    assign unused_data = ^data_in[7:2];
    assign vld_out     = ~empty;

`ifdef ROUTER_CTRL_TIMEOUT_EN
    router_timeout u_timeout [2:0] (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out),
        .rd         (read_enb),
        .soft_reset (soft_reset)
    );

    always_comb begin
        case (addr_reg)
            2'd0:    sel_soft_reset = soft_reset[0];
            2'd1:    sel_soft_reset = soft_reset[1];
            2'd2:    sel_soft_reset = soft_reset[2];
            default: sel_soft_reset = 1'b0;
        endcase
    end
`else
    logic unused_read_enb;
    assign unused_read_enb = ^read_enb;
    assign soft_reset      = 3'b000;
    assign sel_soft_reset  = 1'b0;
`endif

    // Per-address selects; address 3 maps to no FIFO
    always_comb begin
        case (hdr_addr)
            2'd0:    hdr_empty = empty[0];
            2'd1:    hdr_empty = empty[1];
            2'd2:    hdr_empty = empty[2];
            default: hdr_empty = 1'b0;
        endcase
    end

    always_comb begin
        reg_empty   = 1'b0;
        fifo_full   = 1'b0;
        addr_onehot = 3'b000;
        case (addr_reg)
            2'd0: begin reg_empty = empty[0]; fifo_full = full[0]; addr_onehot = 3'b001; end
            2'd1: begin reg_empty = empty[1]; fifo_full = full[1]; addr_onehot = 3'b010; end
            2'd2: begin reg_empty = empty[2]; fifo_full = full[2]; addr_onehot = 3'b100; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            addr_reg <= 2'd0;
        else if (state == DECODE_ADDRESS && pkt_valid)
            addr_reg <= hdr_addr;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            state <= DECODE_ADDRESS;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS:
                if (pkt_valid && hdr_addr != 2'd3)
                    next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                next_state = LOAD_DATA;
            LOAD_DATA:
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            LOAD_PARITY:
                next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                if (reg_empty) next_state = LOAD_FIRST_DATA;
            default:
                next_state = DECODE_ADDRESS;
        endcase
        // A flush of the FIFO being written abandons the packet
        if (sel_soft_reset)
            next_state = DECODE_ADDRESS;
    end

    // Outputs are held at their idle values while resetn is low, before the reset edge lands
    always_comb begin
        detect_add  = 1'b1;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
        busy        = 1'b0;
        write_enb   = 3'b000;
        if (resetn) begin
            detect_add  = (state == DECODE_ADDRESS);
            lfd_state   = (state == LOAD_FIRST_DATA);
            ld_state    = (state == LOAD_DATA);
            laf_state   = (state == LOAD_AFTER_FULL);
            full_state  = (state == FIFO_FULL_STATE);
            rst_int_reg = (state == CHECK_PARITY_ERROR);
            busy        = !(state == DECODE_ADDRESS || state == LOAD_DATA);
            if (state inside {LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY})
                write_enb = addr_onehot;
        end
    end
endmodule

// File: tb/tb_router_ctrl.sv
// Directed self-checking bench for router_ctrl; timeout checks follow ROUTER_CTRL_TIMEOUT_EN.
module tb_router_ctrl;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] empty = 3'b111;
    logic [2:0] full = 3'b000;
    logic [2:0] read_enb = 3'b000;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic [2:0] write_enb, soft_reset, vld_out;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy, fifo_full;

    int errors = 0;
    int checks = 0;

    // {detect_add, lfd, ld, laf, full_state, rst_int_reg, busy}
    localparam logic [6:0] S_DA  = 7'b1000000;
    localparam logic [6:0] S_LFD = 7'b0100001;
    localparam logic [6:0] S_LD  = 7'b0010000;
    localparam logic [6:0] S_LAF = 7'b0001001;
    localparam logic [6:0] S_FFS = 7'b0000101;
    localparam logic [6:0] S_LP  = 7'b0000001;
    localparam logic [6:0] S_CPE = 7'b0000011;
    localparam logic [6:0] S_WTE = 7'b0000001;

    logic [6:0] flags;
    assign flags = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};

    router_ctrl dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .empty(empty), .full(full), .read_enb(read_enb), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .write_enb(write_enb), .soft_reset(soft_reset),
        .vld_out(vld_out), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .busy(busy), .fifo_full(fifo_full)
    );

    always #5 clock = ~clock;

    task tick;
        @(posedge clock);
        #1;
    endtask

    task test_reset;
        resetn = 1'b0; empty = 3'b101; full = 3'b001;
        #1;
        checks++; if (flags !== S_DA || write_enb !== 3'b000) begin errors++;
            $display("FAIL reset_pre_edge: flags=%b we=%b want flags=%b we=000", flags, write_enb, S_DA); end
        tick; tick;
        checks++; if (flags !== S_DA || write_enb !== 3'b000 || soft_reset !== 3'b000) begin errors++;
            $display("FAIL reset_state: flags=%b we=%b sr=%b want %b 000 000", flags, write_enb, soft_reset, S_DA); end
        checks++; if (vld_out !== 3'b010) begin errors++;
            $display("FAIL reset_vld_out: got %b want 010", vld_out); end
        checks++; if (fifo_full !== 1'b1) begin errors++;
            $display("FAIL reset_fifo_full: got %b want 1", fifo_full); end
        full = 3'b110;
        #1;
        checks++; if (fifo_full !== 1'b0) begin errors++;
            $display("FAIL reset_fifo_full_low: got %b want 0", fifo_full); end
        resetn = 1'b1; empty = 3'b111; full = 3'b000;
        tick;
        checks++; if (flags !== S_DA) begin errors++;
            $display("FAIL reset_release: flags=%b want %b", flags, S_DA); end
    endtask

    task test_packet;
        logic       pv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] d  [7] = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h5a, 8'h00, 8'h00};
        logic [6:0] es [7] = '{S_LFD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DA};
        logic [2:0] ew [7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        for (int i = 0; i < 7; i++) begin
            pkt_valid = pv[i]; data_in = d[i];
            tick;
            checks++; if (flags !== es[i] || write_enb !== ew[i]) begin errors++;
                $display("FAIL packet step %0d: flags=%b we=%b want flags=%b we=%b", i, flags, write_enb, es[i], ew[i]); end
        end
        full = 3'b010;
        #1;
        checks++; if (fifo_full !== 1'b1) begin errors++;
            $display("FAIL packet_fifo_full_addr1: got %b want 1", fifo_full); end
        full = 3'b000;
    endtask

    task test_wait_empty;
        logic [2:0] em [8] = '{3'b011, 3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        logic       pv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [6:0] es [8] = '{S_WTE, S_WTE, S_WTE, S_LFD, S_LD, S_LP, S_CPE, S_DA};
        logic [2:0] ew [8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
        data_in = 8'h02;
        for (int i = 0; i < 8; i++) begin
            empty = em[i]; pkt_valid = pv[i];
            tick;
            checks++; if (flags !== es[i] || write_enb !== ew[i]) begin errors++;
                $display("FAIL wait_empty step %0d: flags=%b we=%b want flags=%b we=%b", i, flags, write_enb, es[i], ew[i]); end
            if (i == 1) begin
                checks++; if (vld_out !== 3'b100) begin errors++;
                    $display("FAIL wait_vld_out: got %b want 100", vld_out); end
            end
        end
    endtask

    task test_fifo_full;
        logic       pv [19] = '{1,1,1,1,1,1,0,0, 1,1,1,1,1,0,0,0,0,0,0};
        logic [2:0] fl [19] = '{0,0,1,1,0,0,0,0, 0,0,1,0,0,0,1,1,0,0,0};
        logic       lp [19] = '{0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0,0};
        logic       pd [19] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,1,0};
        logic [6:0] es [19] = '{S_LFD, S_LD, S_FFS, S_FFS, S_LAF, S_LP, S_CPE, S_DA,
                                S_LFD, S_LD, S_FFS, S_LAF, S_LD, S_LP, S_CPE, S_FFS, S_LAF, S_DA, S_DA};
        logic [2:0] ew [19] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000,
                                3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        data_in = 8'h00;
        for (int i = 0; i < 19; i++) begin
            pkt_valid = pv[i]; full = fl[i]; low_pkt_valid = lp[i]; parity_done = pd[i];
            tick;
            checks++; if (flags !== es[i] || write_enb !== ew[i]) begin errors++;
                $display("FAIL fifo_full step %0d: flags=%b we=%b want flags=%b we=%b", i, flags, write_enb, es[i], ew[i]); end
        end
        full = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    task test_addr3_reset;
        logic       pv [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] d  [4] = '{8'h03, 8'h03, 8'h05, 8'h44};
        logic [6:0] es [4] = '{S_DA, S_DA, S_LFD, S_LD};
        logic [2:0] ew [4] = '{3'b000, 3'b000, 3'b010, 3'b010};
        for (int i = 0; i < 4; i++) begin
            pkt_valid = pv[i]; data_in = d[i];
            tick;
            checks++; if (flags !== es[i] || write_enb !== ew[i]) begin errors++;
                $display("FAIL addr3 step %0d: flags=%b we=%b want flags=%b we=%b", i, flags, write_enb, es[i], ew[i]); end
        end
        resetn = 1'b0;
        #1;
        checks++; if (flags !== S_DA || write_enb !== 3'b000) begin errors++;
            $display("FAIL midpkt_reset_low: flags=%b we=%b want %b 000", flags, write_enb, S_DA); end
        tick;
        resetn = 1'b1; pkt_valid = 1'b0;
        #1;
        checks++; if (flags !== S_DA || write_enb !== 3'b000) begin errors++;
            $display("FAIL midpkt_reset_edge: flags=%b we=%b want %b 000", flags, write_enb, S_DA); end
        full = 3'b001;
        #1;
        checks++; if (fifo_full !== 1'b1) begin errors++;
            $display("FAIL reset_addr_reg: fifo_full=%b want 1", fifo_full); end
        full = 3'b000;
        tick;
        checks++; if (flags !== S_DA) begin errors++;
            $display("FAIL post_reset_idle: flags=%b want %b", flags, S_DA); end
    endtask

`ifdef ROUTER_CTRL_TIMEOUT_EN
    task test_timeout;
        logic [2:0] exp_sr;
        pkt_valid = 1'b0; empty = 3'b111; read_enb = 3'b000;
        tick;
        empty = 3'b011;
        for (int k = 1; k <= 31; k++) begin
            tick;
            if (k >= 29) begin
                exp_sr = (k == 30) ? 3'b100 : 3'b000;
                checks++; if (soft_reset !== exp_sr || flags !== S_DA) begin errors++;
                    $display("FAIL timeout idle %0d: sr=%b flags=%b want sr=%b flags=%b", k, soft_reset, flags, exp_sr, S_DA); end
            end
        end
        empty = 3'b111;
        tick;
        empty = 3'b011;
        for (int k = 1; k <= 52; k++) begin
            tick;
            if (k == 20) read_enb = 3'b100;
            if (k == 21) read_enb = 3'b000;
            if (k == 30 || k == 50 || k == 51 || k == 52) begin
                exp_sr = (k == 51) ? 3'b100 : 3'b000;
                checks++; if (soft_reset !== exp_sr) begin errors++;
                    $display("FAIL timeout read_pulse %0d: sr=%b want %b", k, soft_reset, exp_sr); end
            end
        end
    endtask

    task test_timeout_override;
        empty = 3'b111;
        tick;
        pkt_valid = 1'b1; data_in = 8'h02; empty = 3'b011;
        for (int k = 1; k <= 31; k++) begin
            tick;
            if (k == 1 || k == 30) begin
                checks++; if (flags !== S_WTE) begin errors++;
                    $display("FAIL override wait %0d: flags=%b want %b", k, flags, S_WTE); end
            end
            if (k == 30) begin
                checks++; if (soft_reset !== 3'b100) begin errors++;
                    $display("FAIL override sr: got %b want 100", soft_reset); end
            end
            if (k == 31) begin
                checks++; if (flags !== S_DA) begin errors++;
                    $display("FAIL override abort: flags=%b want %b", flags, S_DA); end
            end
        end
        pkt_valid = 1'b0; empty = 3'b111;
        tick;
    endtask
`else
    task test_no_timeout;
        pkt_valid = 1'b0; empty = 3'b011; read_enb = 3'b000;
        for (int k = 1; k <= 35; k++) begin
            tick;
            if (k == 30 || k == 35) begin
                checks++; if (soft_reset !== 3'b000 || flags !== S_DA) begin errors++;
                    $display("FAIL no_timeout %0d: sr=%b flags=%b want 000 %b", k, soft_reset, flags, S_DA); end
            end
        end
        empty = 3'b111;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_packet;
        test_wait_empty;
        test_fifo_full;
        test_addr3_reset;
`ifdef ROUTER_CTRL_TIMEOUT_EN
        test_timeout;
        test_timeout_override;
`else
        test_no_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
